// File: rtl/mem_access_initiator.sv
// mem_access_initiator
// Initiator side of the data-memory load/store path. Accepts one request at a
// time, drives the datamem port either as a single aligned transfer or as a
// sequence of single-byte transfers for unaligned addresses, and returns the
// sign/zero-extended load data. Illegal sizes and out-of-range requests are
// answered with an error response without touching memory.
module mem_access_initiator #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] mem_address,
  output logic        mem_we,
  output logic        mem_re,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGNED = 2'd1,
    SPLIT   = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Control state (reset)
  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       err_q;
  logic       err_next;

  // Captured request and load data (not reset; only observed through state-gated decode)
  logic        write_q;
  logic        signed_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [3:0]  size_q;
  logic [63:0] ld_data;

  // Request classification in IDLE
  logic        accept;
  logic        size_ok;
  logic        range_ok;
  logic        is_aligned;
  logic [64:0] end_addr;

  // Only power-of-two sizes up to a doubleword are transferable
  function automatic logic legal_size(input logic [3:0] s);
    return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
  endfunction

  // Fill the bytes above the access size with zeros or copies of the top data bit
  function automatic logic [63:0] extend_load(input logic [63:0] d,
                                              input logic [3:0]  s,
                                              input logic        sgn);
    logic [63:0] r;
    case (s)
      4'd1:    r = {{56{sgn & d[7]}},  d[7:0]};
      4'd2:    r = {{48{sgn & d[15]}}, d[15:0]};
      4'd4:    r = {{32{sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept     = (state == IDLE) && req_valid;
  assign size_ok    = legal_size(req_size);
  // 65-bit sum so an address near 2^64 cannot wrap into the legal range
  assign end_addr   = {1'b0, req_addr} + {61'b0, req_size};
  assign range_ok   = end_addr <= 65'(MEM_SIZE);
  assign is_aligned = (req_addr & {60'b0, req_size - 4'd1}) == 64'd0;

  // State, byte counter and error flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err_q <= err_next;
    end
  end

  // Request capture and load data assembly
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      signed_q <= req_signed;
      addr_q   <= req_addr;
      size_q   <= req_size;
      wdata_q  <= req_wdata;
    end
    if ((state == ALIGNED) && !write_q) begin
      ld_data <= mem_rdata;
    end
    if ((state == SPLIT) && !write_q) begin
      ld_data[{cnt[2:0], 3'b000} +: 8] <= mem_rdata[7:0];
    end
  end

  // Next-state logic and all outputs, decoded from registered state only
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    err_next      = err_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_error    = 1'b0;
    resp_rdata    = 64'd0;
    mem_address   = 64'd0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_wdata     = 64'd0;
    mem_xfer_size = 4'd8;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_next = 4'd0;
          if (!size_ok || !range_ok) begin
            err_next   = 1'b1;
            state_next = RESP;
          end else begin
            err_next   = 1'b0;
            state_next = is_aligned ? ALIGNED : SPLIT;
          end
        end
      end
      ALIGNED: begin
        mem_address   = addr_q;
        mem_xfer_size = size_q;
        mem_we        = write_q;
        mem_re        = !write_q;
        mem_wdata     = wdata_q;
        state_next    = RESP;
      end
      SPLIT: begin
        mem_address   = addr_q + {60'b0, cnt};
        mem_xfer_size = 4'd1;
        mem_we        = write_q;
        mem_re        = !write_q;
        mem_wdata     = {56'b0, wdata_q[{cnt[2:0], 3'b000} +: 8]};
        cnt_next      = cnt + 4'd1;
        if (cnt == (size_q - 4'd1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        if (!write_q && !err_q) begin
          resp_rdata = extend_load(ld_data, size_q, signed_q);
        end
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// tb_mem_access_initiator
// Directed and randomized load/store traffic against mem_access_initiator with
// a behavioural datamem behind it and an independent byte-array reference.
`timescale 1ns/1ps
module tb_mem_access_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [63:0] mem_address;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_wdata;
  logic [3:0]  mem_xfer_size;
  logic [63:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  bit abort    = 1'b0;

  // Behavioural datamem and the bench's own reference image
  logic [7:0] dmem    [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic       mem_clear;

  // Memory-port monitor (cumulative; single writer)
  int          mon_cycles = 0;
  int          mon_sz1    = 0;
  int          mon_sz8    = 0;
  int          mon_we     = 0;
  int          mon_re     = 0;
  logic [63:0] mon_addr [0:15];

  // Per-request snapshot filled by do_req
  int last_cyc, last_sz1, last_sz8, last_we, last_re, last_base;

  always #5 clk = ~clk;

  mem_access_initiator #(.MEM_SIZE(1024)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .mem_address   (mem_address),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_wdata     (mem_wdata),
    .mem_xfer_size (mem_xfer_size),
    .mem_rdata     (mem_rdata)
  );

  // Combinational little-endian read of 8 bytes starting at mem_address
  always_comb begin
    mem_rdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if ((mem_address + 64'(i)) < 64'd1024)
        mem_rdata[8*i +: 8] = dmem[10'(mem_address + 64'(i))];
    end
  end

  // Byte-enabled write of mem_xfer_size bytes on each clock edge
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 8'h00;
    end else if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if ((i < int'(mem_xfer_size)) && ((mem_address + 64'(i)) < 64'd1024))
          dmem[10'(mem_address + 64'(i))] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Record every cycle in which the memory port is active
  always @(posedge clk) begin
    if (mem_we || mem_re) begin
      mon_addr[mon_cycles % 16] = mem_address;
      mon_cycles++;
      if (mem_xfer_size == 4'd1) mon_sz1++;
      if (mem_xfer_size == 4'd8) mon_sz8++;
      if (mem_we) mon_we++;
      if (mem_re) mon_re++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: request is rejected unless size is 1/2/4/8 and the last byte is inside memory
  function automatic logic model_err(input logic [63:0] a, input logic [3:0] sz);
    int s;
    s = int'(sz);
    if (!(s == 1 || s == 2 || s == 4 || s == 8)) return 1'b1;
    return !(a <= 64'(1024 - s));
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [3:0] sz,
                                             input logic sg);
    logic [63:0] v;
    int s;
    s = int'(sz);
    v = 64'd0;
    for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[10'(a + 64'(i))];
    if (sg && v[8*s-1]) begin
      for (int i = s; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic model_store(input logic [63:0] a, input logic [3:0] sz, input logic [63:0] wd);
    for (int i = 0; i < int'(sz); i++) ref_mem[10'(a + 64'(i))] = wd[8*i +: 8];
  endtask

  // One complete request/response; hold = cycles to withhold resp_ready
  task automatic do_req(input logic w, input logic [63:0] a, input logic [3:0] sz,
                        input logic sg, input logic [63:0] wd, input int hold,
                        output logic [63:0] rd, output logic er, output int lat);
    int guard;
    int b_sz1, b_sz8, b_we, b_re;
    logic [63:0] exp_rd;
    rd  = 64'd0;
    er  = 1'b0;
    lat = 0;
    if (abort) return;
    exp_rd = (!w && !model_err(a, sz)) ? model_load(a, sz, sg) : 64'd0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'(req_ready), 64'd1);
      abort = 1'b1;
      return;
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    last_base  = mon_cycles;
    b_sz1      = mon_sz1;
    b_sz8      = mon_sz8;
    b_we       = mon_we;
    b_re       = mon_re;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 64'(resp_valid), 64'd1);
      abort = 1'b1;
      return;
    end
    rd = resp_rdata;
    er = resp_error;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_rdata", resp_rdata, exp_rd);
      check("stall_req_ready", 64'(req_ready), 64'd0);
    end
    last_cyc = mon_cycles - last_base;
    last_sz1 = mon_sz1 - b_sz1;
    last_sz8 = mon_sz8 - b_sz8;
    last_we  = mon_we - b_we;
    last_re  = mon_re - b_re;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("post_hs_req_ready", 64'(req_ready), 64'd1);
    check("post_hs_resp_valid", 64'(resp_valid), 64'd0);
    if (w && !model_err(a, sz)) model_store(a, sz, wd);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        w, sg, e_err;
    logic [63:0] a, wd, e_rd;
    logic [3:0]  sz;
    int          r, e_lat, diff;

    reset_n    = 1'b0;
    mem_clear  = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'd0;
    req_size   = 4'd0;
    req_signed = 1'b0;
    req_wdata  = 64'd0;
    resp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_error", 64'(resp_error), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_mem_address", mem_address, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_xfer_size", 64'(mem_xfer_size), 64'd8);
    @(negedge clk);
    mem_clear = 1'b0;
    reset_n   = 1'b1;

    // Aligned doubleword store then load
    do_req(1'b1, 64'h10, 4'd8, 1'b0, 64'h1122334455667788, 0, rd, er, lat);
    check("st8_err", 64'(er), 64'd0);
    check("st8_lat", 64'(lat), 64'd2);
    check("st8_cycles", 64'(last_cyc), 64'd1);
    check("st8_sz8", 64'(last_sz8), 64'd1);
    check("st8_we", 64'(last_we), 64'd1);
    check("st8_addr", mon_addr[last_base % 16], 64'h10);
    do_req(1'b0, 64'h10, 4'd8, 1'b0, 64'd0, 0, rd, er, lat);
    check("ld8_rdata", rd, 64'h1122334455667788);
    check("ld8_lat", 64'(lat), 64'd2);
    check("ld8_cycles", 64'(last_cyc), 64'd1);
    check("ld8_sz8", 64'(last_sz8), 64'd1);
    check("ld8_re", 64'(last_re), 64'd1);

    // Byte store, signed and unsigned byte load
    do_req(1'b1, 64'h21, 4'd1, 1'b0, 64'h80, 0, rd, er, lat);
    check("st1_lat", 64'(lat), 64'd2);
    do_req(1'b0, 64'h21, 4'd1, 1'b1, 64'd0, 0, rd, er, lat);
    check("ld1s_rdata", rd, 64'hFFFFFFFFFFFFFF80);
    do_req(1'b0, 64'h21, 4'd1, 1'b0, 64'd0, 0, rd, er, lat);
    check("ld1u_rdata", rd, 64'h80);

    // Unaligned word store is split into four byte cycles 0x103..0x106
    do_req(1'b1, 64'h103, 4'd4, 1'b0, 64'hDEADBEEF, 0, rd, er, lat);
    check("st4u_lat", 64'(lat), 64'd5);
    check("st4u_cycles", 64'(last_cyc), 64'd4);
    check("st4u_sz1", 64'(last_sz1), 64'd4);
    for (int i = 0; i < 4; i++)
      check("st4u_addr", mon_addr[(last_base + i) % 16], 64'h103 + 64'(i));
    do_req(1'b0, 64'h103, 4'd4, 1'b0, 64'd0, 0, rd, er, lat);
    check("ld4u_rdata", rd, 64'hDEADBEEF);
    check("ld4u_lat", 64'(lat), 64'd5);
    check("ld4u_re", 64'(last_re), 64'd4);
    // 0x104 holds 0xBE and 0x105 holds 0xAD (little-endian)
    do_req(1'b0, 64'h104, 4'd2, 1'b1, 64'd0, 0, rd, er, lat);
    check("ld2s_rdata", rd, 64'hFFFFFFFFFFFFADBE);
    check("ld2s_lat", 64'(lat), 64'd2);

    // Rejected requests
    do_req(1'b0, 64'd1020, 4'd8, 1'b0, 64'd0, 0, rd, er, lat);
    check("err_range_err", 64'(er), 64'd1);
    check("err_range_rdata", rd, 64'd0);
    check("err_range_lat", 64'(lat), 64'd1);
    check("err_range_cycles", 64'(last_cyc), 64'd0);
    do_req(1'b0, 64'd0, 4'd3, 1'b0, 64'd0, 0, rd, er, lat);
    check("err_size_err", 64'(er), 64'd1);
    check("err_size_rdata", rd, 64'd0);
    check("err_size_cycles", 64'(last_cyc), 64'd0);
    do_req(1'b0, 64'hFFFFFFFFFFFFFFFC, 4'd8, 1'b0, 64'd0, 0, rd, er, lat);
    check("err_wrap_err", 64'(er), 64'd1);
    check("err_wrap_cycles", 64'(last_cyc), 64'd0);
    do_req(1'b1, 64'd1023, 4'd2, 1'b0, 64'hFFFF, 0, rd, er, lat);
    check("err_st_err", 64'(er), 64'd1);
    check("err_st_we", 64'(last_we), 64'd0);
    check("err_st_mem", 64'(dmem[1023]), 64'h00);

    // Last legal doubleword
    do_req(1'b1, 64'd1016, 4'd8, 1'b0, 64'hCAFEF00D12345678, 0, rd, er, lat);
    check("edge_st_err", 64'(er), 64'd0);
    do_req(1'b0, 64'd1016, 4'd8, 1'b0, 64'd0, 0, rd, er, lat);
    check("edge_ld_err", 64'(er), 64'd0);
    check("edge_ld_rdata", rd, 64'hCAFEF00D12345678);

    // Back-pressure: response held 5 cycles
    do_req(1'b0, 64'h10, 4'd8, 1'b0, 64'd0, 5, rd, er, lat);
    check("stall_ld_rdata", rd, 64'h1122334455667788);

    // Reset during the second byte of an unaligned doubleword store
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 64'h201;
    req_size   = 4'd8;
    req_signed = 1'b0;
    req_wdata  = 64'h0102030405060708;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_split_we_b0", 64'(mem_we), 64'd1);
    check("rst_split_addr_b0", mem_address, 64'h201);
    @(posedge clk);
    #1;
    check("rst_split_addr_b1", mem_address, 64'h202);
    reset_n = 1'b0;
    #1;
    check("rst_split_we_drop", 64'(mem_we), 64'd0);
    check("rst_split_req_ready", 64'(req_ready), 64'd1);
    check("rst_split_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_split_byte0", 64'(dmem['h201]), 64'h08);
    check("rst_split_byte1", 64'(dmem['h202]), 64'h00);
    check("rst_split_byte7", 64'(dmem['h208]), 64'h00);
    ref_mem['h201] = 8'h08;

    // Random mix of aligned, unaligned and illegal requests
    for (int n = 0; n < 5000 && !abort; n++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      r  = int'($urandom_range(0, 9));
      case (r)
        0, 1:    sz = 4'd1;
        2, 3:    sz = 4'd2;
        4, 5:    sz = 4'd4;
        6, 7:    sz = 4'd8;
        8:       sz = 4'd3;
        default: sz = 4'd0;
      endcase
      a = 64'($urandom_range(0, 1031));
      if (sz != 4'd3 && sz != 4'd0 && $urandom_range(0, 1) == 1)
        a = a & ~(64'(sz) - 64'd1);
      e_err = model_err(a, sz);
      e_rd  = (!w && !e_err) ? model_load(a, sz, sg) : 64'd0;
      if (e_err) e_lat = 1;
      else if ((a % 64'(sz)) == 64'd0) e_lat = 2;
      else e_lat = int'(sz) + 1;
      do_req(w, a, sz, sg, wd, 0, rd, er, lat);
      check("rnd_err", 64'(er), 64'(e_err));
      check("rnd_rdata", rd, e_rd);
      check("rnd_lat", 64'(lat), 64'(e_lat));
    end

    diff = 0;
    for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) diff++;
    check("final_mem_diff", 64'(diff), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
